pong_game_ctrl: RTL and testbench

Frame-rate game controller for Pong. It owns ball and paddle positions, scores and serve sequencing. Once per video frame it advances the game in a short multi-cycle update inside vertical blanking. Its position outputs drive the pixel renderer directly. Player button inputs and a frame tick from the VGA timing block are its only stimulus.

---
 rtl/pong_game_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame-rate Pong controller owning ball, paddles, scores and serve sequencing
module pong_game_ctrl #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int BALL_SIZE    = 10,
    parameter int PADDLE_W     = 10,
    parameter int PADDLE_H     = 60,
    parameter int PADDLE_ONE_X = 20,
    parameter int PADDLE_TWO_X = 610,
    parameter int BALL_STEP    = 2,
    parameter int PADDLE_STEP  = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       p1_up,
    input  logic       p1_down,
    input  logic       p2_up,
    input  logic       p2_down,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] paddle_one_x,
    output logic [9:0] paddle_one_y,
    output logic [9:0] paddle_two_x,
    output logic [9:0] paddle_two_y,
    output logic [3:0] score_one,
    output logic [3:0] score_two,
    output logic       serving,
    output logic       game_over
);
    typedef enum logic [2:0] {IDLE, SERVE, PLAY, STEP_PAD, STEP_BALL, RESOLVE, OVER} state_t;

    localparam logic [9:0] CX     = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0] CY     = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [9:0] PY0    = 10'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [9:0] BX_MAX = 10'(SCREEN_W - BALL_SIZE);
    localparam logic [9:0] BY_MAX = 10'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0] PY_MAX = 10'(SCREEN_H - PADDLE_H);
    localparam logic [9:0] BS     = 10'(BALL_SIZE);
    localparam logic [9:0] PW     = 10'(PADDLE_W);
    localparam logic [9:0] PH     = 10'(PADDLE_H);
    localparam logic [9:0] P1_X   = 10'(PADDLE_ONE_X);
    localparam logic [9:0] P2_X   = 10'(PADDLE_TWO_X);
    localparam logic [9:0] PS     = 10'(PADDLE_STEP);
    localparam logic [3:0] WIN    = 4'(WIN_SCORE);
    localparam logic [7:0] CNT_LAST = 8'(SERVE_FRAMES - 1);

    state_t     state, state_n;
    logic [9:0] bx_n, by_n, p1_n, p2_n;
    logic [3:0] s1_n, s2_n;
    logic [7:0] cnt, cnt_n;
    logic       dx_neg, dy_neg, dxn_n, dyn_n;
    logic       hit_one, hit_two;

    // one paddle step: single button moves, both or neither hold, clamped to the screen
    function automatic logic [9:0] pad_step(input logic [9:0] y, input logic up, input logic dn);
        return (up && !dn) ? ((y < PS) ? 10'd0 : y - PS) :
               (dn && !up) ? ((y + PS > PY_MAX) ? PY_MAX : y + PS) : y;
    endfunction

    // one ball axis step in signed arithmetic so moving past 0 saturates instead of wrapping
    function automatic logic [9:0] ball_step(input logic [9:0] p, input logic neg, input logic [9:0] pmax);
        logic signed [10:0] t;
        t = neg ? $signed({1'b0, p}) - $signed(11'(BALL_STEP)) : $signed({1'b0, p}) + $signed(11'(BALL_STEP));
        return (t < 0) ? 10'd0 : (t > $signed({1'b0, pmax})) ? pmax : t[9:0];
    endfunction

    assign hit_one = dx_neg && ball_x <= P1_X + PW && ball_x + BS > P1_X &&
                     ball_y + BS > paddle_one_y && ball_y < paddle_one_y + PH;
    assign hit_two = !dx_neg && ball_x + BS >= P2_X && ball_x < P2_X + PW &&
                     ball_y + BS > paddle_two_y && ball_y < paddle_two_y + PH;
    assign paddle_one_x = P1_X;
    assign paddle_two_x = P2_X;

    // state register and all game state; serving/game_over track the next state so they move with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ball_x       <= CX;
            ball_y       <= CY;
            paddle_one_y <= PY0;
            paddle_two_y <= PY0;
            score_one    <= 4'd0;
            score_two    <= 4'd0;
            dx_neg       <= 1'b0;
            dy_neg       <= 1'b0;
            cnt          <= 8'd0;
            serving      <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            state        <= state_n;
            ball_x       <= bx_n;
            ball_y       <= by_n;
            paddle_one_y <= p1_n;
            paddle_two_y <= p2_n;
            score_one    <= s1_n;
            score_two    <= s2_n;
            dx_neg       <= dxn_n;
            dy_neg       <= dyn_n;
            cnt          <= cnt_n;
            serving      <= state_n == SERVE;
            game_over    <= state_n == OVER;
        end
    end

    // next-state and datapath: serve countdown, then paddle, ball and collision steps per frame
    always_comb begin
        state_n = state;
        bx_n    = ball_x;
        by_n    = ball_y;
        p1_n    = paddle_one_y;
        p2_n    = paddle_two_y;
        s1_n    = score_one;
        s2_n    = score_two;
        dxn_n   = dx_neg;
        dyn_n   = dy_neg;
        cnt_n   = cnt;
        case (state)
            IDLE: if (start) begin
                state_n = SERVE;
                cnt_n   = 8'd0;
                bx_n    = CX;
                by_n    = CY;
            end
            SERVE: if (frame_tick) begin
                cnt_n   = cnt + 8'd1;
                state_n = (cnt == CNT_LAST) ? PLAY : SERVE;
            end
            PLAY: state_n = frame_tick ? STEP_PAD : PLAY;
            STEP_PAD: begin
                p1_n    = pad_step(paddle_one_y, p1_up, p1_down);
                p2_n    = pad_step(paddle_two_y, p2_up, p2_down);
                state_n = STEP_BALL;
            end
            STEP_BALL: begin
                bx_n    = ball_step(ball_x, dx_neg, BX_MAX);
                by_n    = ball_step(ball_y, dy_neg, BY_MAX);
                state_n = RESOLVE;
            end
            RESOLVE: begin
                state_n = PLAY;
                dyn_n   = (ball_y == 10'd0) ? 1'b0 : (ball_y == BY_MAX) ? 1'b1 : dy_neg;
                if (hit_one) begin
                    bx_n  = P1_X + PW;
                    dxn_n = 1'b0;
                end else if (hit_two) begin
                    bx_n  = P2_X - BS;
                    dxn_n = 1'b1;
                end else if (ball_x == 10'd0) begin
                    s2_n    = score_two + 4'd1;
                    bx_n    = CX;
                    by_n    = CY;
                    dxn_n   = 1'b1;
                    cnt_n   = 8'd0;
                    state_n = (score_two + 4'd1 == WIN) ? OVER : SERVE;
                end else if (ball_x == BX_MAX) begin
                    s1_n    = score_one + 4'd1;
                    bx_n    = CX;
                    by_n    = CY;
                    dxn_n   = 1'b0;
                    cnt_n   = 8'd0;
                    state_n = (score_one + 4'd1 == WIN) ? OVER : SERVE;
                end
            end
            OVER: if (start) begin
                state_n = SERVE;
                s1_n    = 4'd0;
                s2_n    = 4'd0;
                bx_n    = CX;
                by_n    = CY;
                cnt_n   = 8'd0;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed game scenario with hand-computed ball/paddle waypoints
module tb_pong_game_ctrl;
    logic       clk = 0, rst, frame_tick, start, p1_up, p1_down, p2_up, p2_down;
    logic [9:0] ball_x, ball_y, paddle_one_x, paddle_one_y, paddle_two_x, paddle_two_y;
    logic [3:0] score_one, score_two;
    logic       serving, game_over;
    int         checks = 0, failures = 0;

    pong_game_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
        .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
        .ball_x(ball_x), .ball_y(ball_y),
        .paddle_one_x(paddle_one_x), .paddle_one_y(paddle_one_y),
        .paddle_two_x(paddle_two_x), .paddle_two_y(paddle_two_y),
        .score_one(score_one), .score_two(score_two),
        .serving(serving), .game_over(game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) frame_tick = 1;
            @(negedge clk) frame_tick = 0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic ball_at(input string tag, input int x, input int y);
        check({tag, "_x"}, ball_x, x);
        check({tag, "_y"}, ball_y, y);
    endtask

    task automatic reset_state(input string tag);
        ball_at(tag, 315, 235);
        check({tag, "_p1x"}, paddle_one_x, 20);
        check({tag, "_p1y"}, paddle_one_y, 210);
        check({tag, "_p2x"}, paddle_two_x, 610);
        check({tag, "_p2y"}, paddle_two_y, 210);
        check({tag, "_s1"}, score_one, 0);
        check({tag, "_s2"}, score_two, 0);
        check({tag, "_serving"}, serving, 0);
        check({tag, "_over"}, game_over, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
    endtask

    initial begin
        rst = 1; start = 0; frame_tick = 0;
        p1_up = 0; p1_down = 0; p2_up = 0; p2_down = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        reset_state("rst");
        frames(3);
        reset_state("idle");
        pulse_start();
        check("serve_entry", serving, 1);
        frames(59);
        check("serve59", serving, 1);
        ball_at("serve_hold", 315, 235);
        frames(1);
        check("serve60", serving, 0);
        // first update: ball moves on the edge leaving STEP_BALL
        @(negedge clk) frame_tick = 1;
        @(negedge clk) frame_tick = 0;
        @(negedge clk);
        check("upd_mid_x", ball_x, 315);
        repeat (2) @(negedge clk);
        ball_at("upd1", 317, 237);
        repeat (2) @(negedge clk);
        // paddle clamps
        p1_up = 1; p2_down = 1;
        frames(52);
        check("p1_at2", paddle_one_y, 2);
        check("p2_at418", paddle_two_y, 418);
        frames(1);
        check("p1_clamp", paddle_one_y, 0);
        check("p2_clamp", paddle_two_y, 420);
        frames(1);
        check("p1_stay", paddle_one_y, 0);
        check("p2_stay", paddle_two_y, 420);
        p1_down = 1; p2_up = 1;
        frames(1);
        check("p1_both", paddle_one_y, 0);
        check("p2_both", paddle_two_y, 420);
        ball_at("f56", 427, 347);
        p1_up = 0; p1_down = 0; p2_up = 0; p2_down = 0;
        // bottom wall
        frames(61);
        ball_at("f117", 549, 469);
        frames(1);
        ball_at("f118_wall", 551, 470);
        frames(1);
        ball_at("f119", 553, 468);
        // paddle two hit
        frames(23);
        ball_at("f142", 599, 422);
        frames(1);
        ball_at("p2_hit", 600, 420);
        frames(1);
        ball_at("p2_after", 598, 418);
        // top wall
        frames(208);
        ball_at("top_pre", 182, 2);
        frames(1);
        ball_at("top_wall", 180, 0);
        frames(1);
        ball_at("top_after", 178, 2);
        // left miss
        frames(88);
        ball_at("miss_pre", 2, 178);
        frames(1);
        check("miss1_s2", score_two, 1);
        check("miss1_s1", score_one, 0);
        check("miss1_serving", serving, 1);
        ball_at("miss1_centre", 315, 235);
        // round two: serve toward player one, paddle one hit
        frames(60);
        check("r2_play", serving, 0);
        p1_down = 1;
        frames(1);
        ball_at("r2_g1", 313, 237);
        check("r2_p1_g1", paddle_one_y, 4);
        frames(99);
        check("r2_p1_400", paddle_one_y, 400);
        ball_at("r2_g100", 115, 435);
        p1_down = 0;
        frames(17);
        ball_at("r2_g117", 81, 469);
        frames(1);
        ball_at("r2_wall", 79, 470);
        frames(24);
        ball_at("r2_g142", 31, 422);
        frames(1);
        ball_at("p1_hit", 30, 420);
        check("p1_hit_s1", score_one, 0);
        check("p1_hit_s2", score_two, 1);
        p2_up = 1;
        frames(1);
        ball_at("p1_after", 32, 418);
        check("r2_p2_h1", paddle_two_y, 416);
        frames(51);
        check("r2_p2_212", paddle_two_y, 212);
        ball_at("r2_h52", 134, 316);
        p2_up = 0;
        frames(158);
        ball_at("r2_top", 450, 0);
        frames(1);
        ball_at("r2_top_after", 452, 2);
        frames(89);
        check("miss2_s1", score_one, 1);
        check("miss2_s2", score_two, 1);
        check("miss2_serving", serving, 1);
        ball_at("miss2_centre", 315, 235);
        // right-side misses until player one wins
        for (int r = 0; r < 6; r++) begin
            frames(60);
            check("rr_play", serving, 0);
            frames(157);
            ball_at("rr_f157", 629, (r % 2 == 0) ? 392 : 78);
            frames(1);
            check("rr_s1", score_one, 2 + r);
            check("rr_s2", score_two, 1);
            check("rr_over", game_over, (r == 5) ? 1 : 0);
            check("rr_serving", serving, (r < 5) ? 1 : 0);
        end
        frames(5);
        ball_at("over_frozen", 315, 235);
        check("over_s1", score_one, 7);
        check("over_still", game_over, 1);
        pulse_start();
        check("restart_s1", score_one, 0);
        check("restart_s2", score_two, 0);
        check("restart_serving", serving, 1);
        check("restart_over", game_over, 0);
        // reset in the middle of an update
        frames(60);
        p1_up = 1;
        @(negedge clk) frame_tick = 1;
        @(negedge clk) frame_tick = 0;
        @(negedge clk);
        check("mid_p1", paddle_one_y, 396);
        rst = 1;
        @(negedge clk) rst = 0;
        p1_up = 0;
        reset_state("mid_rst");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
